shl_seq: RTL and testbench

//  Multi-cycle left shifter for the 16-bit datapath. It is the left-direction counterpart of the combinational
//  SRA unit: it performs logical shift-left (SLL) and, optionally, rotate-left (ROL) iteratively.

---
 rtl/shift_pkg.sv | 29 ++
 rtl/shl_step.sv | 41 ++++
 rtl/shl_seq.sv | 114 +++++++++++
 tb/tb_shl_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift units: op codes, shifter FSM states, coarse step size.
// The legality helper depends on SHL_SEQ_ROTATE_EN.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_ROL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned COARSE_STEP_DEF = 4;

  // ROL is only legal when the rotate path is built.
  function automatic logic op_legal(logic [1:0] op);
`ifdef SHL_SEQ_ROTATE_EN
    return (op == OP_SLL) || (op == OP_ROL);
`else
    return op == OP_SLL;
`endif
  endfunction

endpackage

// File: rtl/shl_step.sv
// Combinational single step of the left shifter: shift or rotate by COARSE_STEP or by 1.
// The rotate path exists only when SHL_SEQ_ROTATE_EN is defined.
module shl_step #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned COARSE_STEP = 4
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             coarse,
  input  logic             rotate,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] sll_c;
  logic [WIDTH-1:0] sll_f;

  assign sll_c = acc << COARSE_STEP;
  assign sll_f = acc << 1;

`ifdef SHL_SEQ_ROTATE_EN
  logic [WIDTH-1:0] rol_c;
  logic [WIDTH-1:0] rol_f;

  assign rol_c = sll_c | (acc >> (WIDTH - COARSE_STEP));
  assign rol_f = sll_f | (acc >> (WIDTH - 1));

  always_comb begin
    acc_next = coarse ? sll_c : sll_f;
    if (rotate) begin
      acc_next = coarse ? rol_c : rol_f;
    end
  end
`else
  logic unused_rotate;
  assign unused_rotate = rotate;

  always_comb begin
    acc_next = coarse ? sll_c : sll_f;
  end
`endif

endmodule

// File: rtl/shl_seq.sv
// Multi-cycle left shifter (SLL, optional ROL under SHL_SEQ_ROTATE_EN): coarse steps while the
// remaining count allows, then single-bit steps; result and err presented with a done pulse.
module shl_seq
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned CNT_W       = $clog2(WIDTH),
  parameter int unsigned COARSE_STEP = shift_pkg::COARSE_STEP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d;

  logic             coarse;
  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] rem_next;
  logic [WIDTH-1:0] acc_step;
  logic             legal;

  // A fine step is only taken when 0 < rem < COARSE_STEP, so rem cannot underflow.
  assign coarse   = rem_q >= CNT_W'(COARSE_STEP);
  assign step     = coarse ? CNT_W'(COARSE_STEP) : CNT_W'(1);
  assign rem_next = rem_q - step;
  assign legal    = op_legal(op);

  shl_step #(
    .WIDTH      (WIDTH),
    .COARSE_STEP(COARSE_STEP)
  ) u_step (
    .acc     (acc_q),
    .coarse  (coarse),
    .rotate  (op_q == OP_ROL),
    .acc_next(acc_step)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    out_d   = out_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = in_data;
          rem_d = cnt;
          op_d  = op;
          if ((cnt != '0) && legal) begin
            state_d = StShift;
          end else begin
            state_d = StDone;
            out_d   = legal ? in_data : '0;
            err_d   = ~legal;
          end
        end
      end
      StShift: begin
        acc_d = acc_step;
        rem_d = rem_next;
        if (rem_next == '0) begin
          state_d = StDone;
          out_d   = acc_step;
          err_d   = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign busy = state_q != StIdle;
  assign done = state_q == StDone;
  assign out  = out_q;
  assign err  = err_q;

endmodule

// File: tb/tb_shl_seq.sv
// Self-checking bench for shl_seq; expectations depend on SHL_SEQ_ROTATE_EN.
module tb_shl_seq;

`ifdef SHL_SEQ_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_data = '0;
  logic [3:0]  cnt = '0;
  logic [1:0]  op = '0;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] out;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  shl_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .in_data(in_data),
    .cnt    (cnt),
    .op     (op),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .err    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(logic [15:0] d, logic [3:0] c, logic [1:0] o);
    exp_t        e;
    logic [15:0] sll;
    logic [15:0] rol;
    logic        lg;
    sll = d << c;
    rol = (d << c) | (d >> (5'd16 - {1'b0, c}));
    lg  = (o == 2'b00) || (ROT && (o == 2'b01));
    if (!lg) begin
      e.out = '0;
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      e.out = (o == 2'b01) ? rol : sll;
      e.err = 1'b0;
      e.lat = 1 + int'(c) / 4 + int'(c) % 4;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request; returns in the first cycle after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o);
    sb.push_back(model(d, c, o));
    in_data = d;
    cnt     = c;
    op      = o;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Wait (bounded) for done, then compare against the scoreboard head. Returns in the done cycle.
  task automatic collect(input string name);
    int   lat;
    exp_t e;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done not seen in %0d cycles, expected latency %0d", name, lat, e.lat);
      return;
    end
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
    end
    checks++;
    if (out !== e.out) begin
      errors++;
      $display("FAIL %s out: got %h expected %h", name, out, e.out);
    end
    checks++;
    if (err !== e.err) begin
      errors++;
      $display("FAIL %s err: got %b expected %b", name, err, e.err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    checks++; if (out !== 16'h0) begin errors++; $display("FAIL reset out: got %h expected 0000", out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b expected 0", err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sll();
    send(16'h8001, 4'd5, 2'b00);
    collect("sll_8001_5");
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL sll_pulse done: got %b expected 0", done); end
    checks++;
    if (out !== 16'h0020) begin errors++; $display("FAIL sll_hold out: got %h expected 0020", out); end
  endtask

  // Legal ROL when built with rotate, otherwise the illegal-op response.
  task automatic test_rol();
    send(16'h8001, 4'd5, 2'b01);
    collect("rol_8001_5");
    tick();
  endtask

  task automatic test_long();
    int   busy_cnt;
    int   ndone;
    int   done_lat;
    exp_t e;
    send(16'hFFFF, 4'd15, 2'b00);
    e        = sb.pop_front();
    busy_cnt = 0;
    ndone    = 0;
    done_lat = 0;
    for (int i = 1; i <= 14; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          done_lat = i;
          checks++;
          if (out !== e.out) begin
            errors++;
            $display("FAIL long out: got %h expected %h", out, e.out);
          end
        end
      end
      if (i == 2) begin
        in_data = 16'h0001;
        cnt     = 4'd1;
        start   = 1'b1;
      end
      if (i == 3) start = 1'b0;
      tick();
    end
    checks++;
    if (busy_cnt != 7) begin errors++; $display("FAIL long busy cycles: got %0d expected 7", busy_cnt); end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL long done count: got %0d expected 1", ndone); end
    checks++;
    if (done_lat != e.lat) begin
      errors++;
      $display("FAIL long latency: got %0d expected %0d", done_lat, e.lat);
    end
  endtask

  task automatic test_illegal();
    send(16'hABCD, 4'd7, 2'b11);
    collect("illegal_rsv");
    tick();
    send(16'h5A5A, 4'd3, 2'b10);
    collect("illegal_sra");
    tick();
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [3:0]  c;
    logic [1:0]  o;
    for (int i = 0; i < 10; i++) begin
      d = 16'($urandom);
      c = 4'($urandom_range(0, 15));
      o = 2'($urandom_range(0, 3));
      send(d, c, o);
      collect("random");
      tick();
    end
  endtask

  task automatic test_back_to_back();
    send(16'h1234, 4'd0, 2'b00);
    collect("zero_cnt");
    // Start raised in the done cycle must be ignored, then taken in the following idle cycle.
    sb.push_back(model(16'h00F0, 4'd4, 2'b00));
    in_data = 16'h00F0;
    cnt     = 4'd4;
    op      = 2'b00;
    start   = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done busy: got %b expected 0", busy); end
    tick();
    start = 1'b0;
    collect("back_to_back");
    tick();
  endtask

  task automatic test_reset_mid();
    int ndone;
    send(16'h0003, 4'd12, 2'b00);
    void'(sb.pop_front());
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst done: got %b expected 0", done); end
    checks++; if (out !== 16'h0) begin errors++; $display("FAIL midrst out: got %h expected 0000", out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst err: got %b expected 0", err); end
    #3 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL midrst stray done: got %0d expected 0", ndone); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy after: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_rol();
    test_long();
    test_illegal();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
